// File: rtl/adder_result_accumulator.sv
// Burst accumulator for adder results: sums COUNT beats (or a flushed partial burst) and holds the result on a valid/ready output.
// Optional build macro ACC_SATURATE_EN: clamp the accumulator at 2^ACC_W-1 instead of wrapping.
module adder_result_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int ACC_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             beat;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx;
  logic             done;

  // in_ready depends only on the state register (and reset), never on out_ready
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    beat    = in_valid && in_ready;
    sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
    carry   = sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_add = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
    acc_nx  = beat ? acc_add : acc_q;
    ovf_nx  = ovf_q | (beat & carry);
    cnt_nx  = cnt_q + CNT_W'(beat);
    // A flush only closes the burst if at least one beat (including this cycle's) is in it
    done    = (state_q == ACCUM) &&
              ((beat && (cnt_q == LAST_CNT)) || (flush && (cnt_nx != '0)));

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ACCUM: begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        ovf_d = ovf_nx;
        if (done) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_sum_d   = acc_nx;
          out_count_d = cnt_nx;
          out_ovf_d   = ovf_nx;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
